// File: rtl/seq_pkg.sv
// Shared types and constants for the 1011 sequence transmitter/detector pair.
package seq_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

  localparam int                   SEQ_PAT_W   = 4;
  localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN = 4'b1011;
  localparam int                   SEQ_GAP_MAX = 15;
endpackage

// File: rtl/seq_tx_shreg.sv
// MSB-first bit selector over a constant pattern plus remaining-frame counter.
// SEQ_TX_PARITY_EN appends one even-parity bit after the last pattern bit.
module seq_tx_shreg
  import seq_pkg::*;
#(
  parameter int               PAT_W   = SEQ_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = SEQ_PATTERN
) (
  input  logic       clk,
  input  logic       res,
  input  logic       load,
  input  logic       step,
  input  logic       restart,
  input  logic [2:0] rep,
  output logic       bit_o,
  output logic       last,
  output logic       frames_zero
);
  localparam int             IW      = $clog2(PAT_W);
  localparam logic [IW-1:0] IDX_TOP = IW'(PAT_W - 1);

  logic [IW-1:0] idx_q;
  logic [2:0]    frames_q;

  always_ff @(posedge clk) begin
    if (res) begin
      idx_q    <= IDX_TOP;
      frames_q <= '0;
    end else if (load) begin
      idx_q    <= IDX_TOP;
      frames_q <= rep;
    end else if (restart) begin
      idx_q    <= IDX_TOP;
      frames_q <= frames_q - 3'd1;
    end else if (step && idx_q != '0) begin
      idx_q <= idx_q - IW'(1);
    end
  end

`ifdef SEQ_TX_PARITY_EN
  logic par_q;

  // Stepping past index 0 enters the parity slot instead of wrapping.
  always_ff @(posedge clk) begin
    if (res || load || restart) par_q <= 1'b0;
    else if (step && idx_q == '0) par_q <= 1'b1;
  end

  assign last  = par_q;
  assign bit_o = par_q ? ^PATTERN : PATTERN[idx_q];
`else
  assign last  = (idx_q == '0);
  assign bit_o = PATTERN[idx_q];
`endif

  assign frames_zero = (frames_q == 3'd0);
endmodule

// File: rtl/moore_seq_tx.sv
// Moore serial pattern transmitter: repeats PATTERN MSB-first rep+1 times with GAP idle cycles between.
// Optional parity bit per frame via SEQ_TX_PARITY_EN.
module moore_seq_tx
  import seq_pkg::*;
#(
  parameter int               PAT_W   = SEQ_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = SEQ_PATTERN,
  parameter int               GAP     = 1
) (
  input  logic       clk,
  input  logic       res,
  input  logic       start,
  input  logic [2:0] rep,
  output logic       a,
  output logic       busy,
  output logic       done
);
  localparam int             GW     = $clog2(SEQ_GAP_MAX + 1);
  localparam logic [GW-1:0] GAP_LD = GW'((GAP > 0) ? GAP - 1 : 0);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_SEND = ST_SEND;
  localparam logic [1:0] S_GAP  = ST_GAP;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          ld, step, restart;
  logic          bit_s, last, frames_zero;

  seq_tx_shreg #(.PAT_W(PAT_W), .PATTERN(PATTERN)) u_shreg (
    .clk         (clk),
    .res         (res),
    .load        (ld),
    .step        (step),
    .restart     (restart),
    .rep         (rep),
    .bit_o       (bit_s),
    .last        (last),
    .frames_zero (frames_zero)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    ld      = 1'b0;
    step    = 1'b0;
    restart = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        ld      = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!last) step = 1'b1;
        else if (frames_zero) state_d = S_DONE;
        else if (GAP > 0) begin
          state_d = S_GAP;
          gap_d   = GAP_LD;
        end else restart = 1'b1;  // back-to-back frames
      end
      S_GAP: begin
        if (gap_q == '0) begin
          restart = 1'b1;
          state_d = S_SEND;
        end else gap_d = gap_q - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  assign a    = (state_q == S_SEND) & bit_s;
  assign busy = (state_q == S_SEND) | (state_q == S_GAP);
  assign done = (state_q == S_DONE);
endmodule

// File: tb/tb_moore_seq_tx.sv
// Directed bench for moore_seq_tx: vector table, multi-frame streams, and a 1011 loopback detector.
module tb_moore_seq_tx;
  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       start = 1'b0, start0 = 1'b0;
  logic [2:0] rep = 3'd0, rep0 = 3'd0;
  logic       a, busy, done;
  logic       a0, busy0, done0;
  int         checks = 0;
  int         errors = 0;

`ifdef SEQ_TX_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif
  localparam logic [4:0] FRAME = 5'b10111;

  always #5 clk = ~clk;

  moore_seq_tx u_dut (
    .clk(clk), .res(res), .start(start), .rep(rep),
    .a(a), .busy(busy), .done(done)
  );

  moore_seq_tx #(.GAP(0)) u_dut0 (
    .clk(clk), .res(res), .start(start0), .rep(rep0),
    .a(a0), .busy(busy0), .done(done0)
  );

  // Non-overlapping 1011 Moore detector fed by the GAP=1 instance.
  logic [2:0] det_st;
  int         det_cnt = 0;
  always @(posedge clk) begin
    if (res) det_st <= 3'd0;
    else begin
      if (det_st == 3'd4) det_cnt <= det_cnt + 1;
      case (det_st)
        3'd0:    det_st <= a ? 3'd1 : 3'd0;
        3'd1:    det_st <= a ? 3'd1 : 3'd2;
        3'd2:    det_st <= a ? 3'd3 : 3'd0;
        3'd3:    det_st <= a ? 3'd4 : 3'd2;
        default: det_st <= a ? 3'd1 : 3'd0;
      endcase
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic get_out(input bit sel, output logic oa, output logic ob, output logic od);
    oa = sel ? a0 : a;
    ob = sel ? busy0 : busy;
    od = sel ? done0 : done;
  endtask

  // Starts a transfer and checks the full expected stream, busy length and a single done pulse.
  task automatic run_seq(input string nm, input bit sel, input int r, input int gap, input int poke);
    logic       q[$];
    logic [4:0] fv;
    logic       oa, ob, od;
    int         nbusy, ndone;
    fv = FRAME;
    nbusy = 0;
    ndone = 0;
    for (int f = 0; f <= r; f++) begin
      for (int j = 0; j < FL; j++) q.push_back(fv[4-j]);
      if (f < r) for (int g = 0; g < gap; g++) q.push_back(1'b0);
    end
    if (sel) begin start0 = 1'b1; rep0 = 3'(r); end
    else     begin start  = 1'b1; rep  = 3'(r); end
    tick();
    start = 1'b0; start0 = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      get_out(sel, oa, ob, od);
      chk({nm, " a"}, int'(oa), int'(q[i]));
      if (ob) nbusy++;
      if (od) ndone++;
      if (i == poke) begin start = 1'b1; rep = 3'd7; end
      tick();
      start = 1'b0; rep = 3'd0;
    end
    for (int p = 0; p < 3; p++) begin
      get_out(sel, oa, ob, od);
      chk({nm, " post a"}, int'(oa), 0);
      chk({nm, " post busy"}, int'(ob), 0);
      chk({nm, " post done"}, int'(od), (p == 0) ? 1 : 0);
      if (od) ndone++;
      tick();
    end
    chk({nm, " busy cycles"}, nbusy, q.size());
    chk({nm, " done pulses"}, ndone, 1);
  endtask

  typedef struct {
    logic       res;
    logic       start;
    logic [2:0] rep;
    logic       a;
    logic       busy;
    logic       done;
  } vec_t;

  initial begin
    vec_t tv[$];
    int   d0;
    tv.push_back('{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b1, 3'd0, 1'b1, 1'b1, 1'b0});
    tv.push_back('{1'b0, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0});
    tv.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0});
`ifdef SEQ_TX_PARITY_EN
    tv.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0});
`endif
    tv.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1});
    tv.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});
    tv.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < tv.size(); i++) begin
      res = tv[i].res; start = tv[i].start; rep = tv[i].rep;
      tick();
      chk($sformatf("vec%0d a", i), int'(a), int'(tv[i].a));
      chk($sformatf("vec%0d busy", i), int'(busy), int'(tv[i].busy));
      chk($sformatf("vec%0d done", i), int'(done), int'(tv[i].done));
    end
    start = 1'b0; rep = 3'd0;

    d0 = det_cnt;
    run_seq("rep2_gap1", 1'b0, 2, 1, -1);
    chk("loopback detections", det_cnt - d0, 3);

    run_seq("rep1_gap0", 1'b1, 1, 0, -1);

    run_seq("start_ignored", 1'b0, 0, 1, 1);

    // Reset two bits into a frame.
    start = 1'b1; rep = 3'd0;
    tick();
    start = 1'b0;
    chk("rst bit0", int'(a), 1);
    tick();
    chk("rst bit1", int'(a), 0);
    res = 1'b1;
    tick();
    res = 1'b0;
    chk("rst a", int'(a), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    tick();
    chk("rst idle busy", int'(busy), 0);
    chk("rst idle done", int'(done), 0);
    run_seq("after_rst", 1'b0, 0, 1, -1);

    // start held high re-triggers on the IDLE cycle after DONE.
    start = 1'b1; rep = 3'd0;
    tick();
    for (int i = 0; i < FL; i++) tick();
    chk("held done", int'(done), 1);
    tick();
    chk("held idle busy", int'(busy), 0);
    chk("held idle done", int'(done), 0);
    tick();
    chk("held retrig busy", int'(busy), 1);
    chk("held retrig a", int'(a), 1);
    start = 1'b0;
    for (int n = 0; n < 30 && !done; n++) tick();
    chk("held second done", int'(done), 1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
